spm_seq_mult: RTL and testbench

//  Handshaked, parametrised serial-parallel multiplier. Computes a full-width XW x YW product using a carry-save cell array.
//  x is loaded in parallel; y is shifted in LSB-first; product bits are collected serially into a result register.

---
 rtl/spm_seq_mult_pkg.sv | 15 +
 rtl/spm_seq_mult_if.sv | 26 ++
 rtl/spm_seq_mult_csa_cell.sv | 34 +++
 rtl/spm_seq_mult.sv | 107 ++++++++++
 tb/tb_spm_seq_mult.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/spm_seq_mult_pkg.sv
// spm_pkg: shared FSM state type, width helper and accumulator guard size for spm_seq_mult
package spm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int ACC_GUARD = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spm_seq_mult_if.sv
// spm_seq_mult_if: operand/product handshake bundle for spm_seq_mult
interface spm_seq_mult_if #(
    parameter int XW = 32,
    parameter int YW = 32
) ();
    localparam int PW = XW + YW;

    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p;

    modport master (
        output in_valid, in_signed, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_signed, in_x, in_y, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/spm_seq_mult_csa_cell.sv
// spm_csa_cell: one carry-save cell of the serial-parallel array; the top cell can act as a serial negator
module spm_csa_cell #(
    parameter bit TOP = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sgn,
    input  logic a,
    input  logic sin,
    output logic s
);
    logic c;
    logic neg;

    // In signed mode the top row carries negative weight, so it emits the
    // two's complement of its partial-product stream (c remembers "a 1 was seen").
    assign neg = TOP && sgn;

    // Sum/carry state, cleared when a new transaction is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 1'b0;
            c <= 1'b0;
        end else if (clr) begin
            s <= 1'b0;
            c <= 1'b0;
        end else if (en) begin
            s <= neg ? a ^ c : a ^ sin ^ c;
            c <= neg ? a | c : (a & sin) | (a & c) | (sin & c);
        end
    end
endmodule

// File: rtl/spm_seq_mult.sv
// spm_seq_mult: handshaked serial-parallel multiplier (x parallel, y LSB-first); optional accumulator under SPM_ACCUM_EN
module spm_seq_mult
    import spm_pkg::*;
#(
    parameter int XW = 32,
    parameter int YW = 32
) (
    input  logic clk,
    input  logic rst_n,
    spm_seq_mult_if.slave bus,
    output logic busy
`ifdef SPM_ACCUM_EN
    ,
    input  logic acc_clr,
    output logic [XW+YW+ACC_GUARD-1:0] acc
`endif
);
    localparam int PW = XW + YW;
    localparam int CW = clog2(PW + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [XW-1:0] xr;
    logic [YW-1:0] ysh;
    logic          sgn;
    logic [PW-1:0] pr;
    logic          rdy;
    logic          vld;
    logic          start;
    logic          run;
    logic [XW:0]   s;

    assign start        = bus.in_valid && rdy;
    assign run          = state == RUN;
    assign s[XW]        = 1'b0;
    assign bus.in_ready = rdy;
    assign bus.out_valid = vld;
    assign bus.out_p    = pr;

    genvar i;
    generate
        for (i = 0; i < XW; i++) begin : g_cell
            spm_csa_cell #(.TOP(i == XW - 1)) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (start),
                .en    (run),
                .sgn   (sgn),
                .a     (xr[i] & ysh[0]),
                .sin   (s[i+1]),
                .s     (s[i])
            );
        end
    endgenerate

    // Control FSM: operand latch, y shifter (sign-extending), counter and product shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy   <= 1'b1;
            vld   <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
            xr    <= '0;
            ysh   <= '0;
            sgn   <= 1'b0;
            pr    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state <= RUN;
                    rdy   <= 1'b0;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    xr    <= bus.in_x;
                    ysh   <= bus.in_y;
                    sgn   <= bus.in_signed;
                end
                RUN: begin
                    ysh <= {sgn & ysh[YW-1], ysh[YW-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt != '0) pr <= {s[0], pr[PW-1:1]};
                    if (cnt == CW'(PW)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        vld   <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state <= IDLE;
                    vld   <= 1'b0;
                    rdy   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPM_ACCUM_EN
    // Running sum of consumed products, extended according to the latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (vld && bus.out_ready) acc <= acc + {{ACC_GUARD{sgn & pr[PW-1]}}, pr};
    end
`endif
endmodule

// File: tb/tb_spm_seq_mult.sv
// tb_spm_seq_mult: scoreboard bench for spm_seq_mult at XW=YW=8 (accumulator checks when SPM_ACCUM_EN is defined)
module tb_spm_seq_mult;
    localparam int XW = 8;
    localparam int YW = 8;
    localparam int PW = XW + YW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic [PW-1:0] exp_q[$];
`ifdef SPM_ACCUM_EN
    logic acc_clr = 1'b0;
    logic [PW+7:0] acc;
`endif

    spm_seq_mult_if #(.XW(XW), .YW(YW)) bus ();

    spm_seq_mult #(.XW(XW), .YW(YW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef SPM_ACCUM_EN
        ,
        .acc_clr (acc_clr),
        .acc     (acc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic sg, input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [PW-1:0] xe, ye;
        xe = sg ? {{YW{x[XW-1]}}, x} : {{YW{1'b0}}, x};
        ye = sg ? {{XW{y[YW-1]}}, y} : {{XW{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic do_op(input logic sg, input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic [PW-1:0] exp, input int hold, input logic clr);
        int n;
        logic [PW-1:0] held;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_signed = sg; bus.in_x = x; bus.in_y = y;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("busy_run", busy, 1'b1);
        check("ready_run", bus.in_ready, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency", n, PW + 1);
        check("busy_done", busy, 1'b0);
        held = bus.out_p;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_x = 8'd7; bus.in_y = 8'd9;
            @(posedge clk);
            #1 check("hold_p", bus.out_p, held);
            check("hold_ready", bus.in_ready, 1'b0);
            check("hold_valid", bus.out_valid, 1'b1);
        end
        if (exp_q.size() == 0) check("sb_empty", 1'b1, 1'b0);
        else check("product", bus.out_p, exp_q.pop_front());
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
`ifdef SPM_ACCUM_EN
        acc_clr = clr;
`endif
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
`ifdef SPM_ACCUM_EN
        acc_clr = 1'b0;
`endif
        check("post_valid", bus.out_valid, 1'b0);
        check("post_ready", bus.in_ready, 1'b1);
        check("post_busy", busy, 1'b0);
    endtask

    typedef struct { logic sg; logic [7:0] x; logic [7:0] y; logic [15:0] p; } vec_t;
    vec_t tbl[5];

    initial begin
        logic [7:0] rx, ry;
        logic rs;
        tbl[0] = '{1'b0, 8'd3,   8'd5,   16'h000F};
        tbl[1] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
        tbl[2] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        tbl[3] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        tbl[4] = '{1'b1, 8'h7F,  8'h7F,  16'h3F01};
        bus.in_valid = 1'b0; bus.in_signed = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_p", bus.out_p, 16'h0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        foreach (tbl[k]) do_op(tbl[k].sg, tbl[k].x, tbl[k].y, tbl[k].p, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            rs = 1'($urandom_range(1)); rx = 8'($urandom); ry = 8'($urandom);
            do_op(rs, rx, ry, model(rs, rx, ry), 0, 1'b0);
        end
        do_op(1'b0, 8'd12, 8'd10, 16'd120, 10, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_signed = 1'b0; bus.in_x = 8'd100; bus.in_y = 8'd3;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("abort_ready", bus.in_ready, 1'b1);
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_p", bus.out_p, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SPM_ACCUM_EN
        check("acc_rst", acc, 24'h0);
`endif
        do_op(1'b0, 8'd3, 8'd5, 16'h000F, 0, 1'b0);
        do_op(1'b0, 8'd2, 8'd2, 16'h0004, 0, 1'b0);
`ifdef SPM_ACCUM_EN
        check("acc_sum", acc, 24'd19);
        do_op(1'b0, 8'd6, 8'd7, 16'd42, 0, 1'b1);
        check("acc_clr", acc, 24'h0);
        do_op(1'b1, 8'hFF, 8'h01, 16'hFFFF, 0, 1'b0);
        check("acc_sext", acc, 24'hFFFFFF);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
